reg_file_sb: RTL

Parametrised integer register file with a pending-write scoreboard for the pipelined RISC-V core. It provides one synchronous write port and two combinational read ports. Register 0 is optionally hard-wired to zero, and an optional write-to-read bypass is included. Per-register busy bits are set when an instruction issues and cleared at writeback, so decode can detect RAW hazards.

---
 rtl/reg_file_sb_if.sv | 30 +++
 rtl/reg_file_sb.sv | 102 ++++++++++
 2 files changed

// File: rtl/reg_file_sb_if.sv
// Register-file bus: one write port, two read ports, and the issue/flush controls for the scoreboard.
// master = core pipeline side (drives indices, write data and issue/flush); slave = register file.
// Read data and busy flags are combinational from the slave. There is no handshake, so every access is accepted in its cycle.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic [DATA_W-1:0] dataW_i;
    logic [ADDR_W-1:0] rsW_i;
    logic              RegWEn_i;
    logic [ADDR_W-1:0] rs1_i;
    logic [ADDR_W-1:0] rs2_i;
    logic [DATA_W-1:0] data1_o;
    logic [DATA_W-1:0] data2_o;
    logic              busy1_o;
    logic              busy2_o;
    logic              issue_i;
    logic [ADDR_W-1:0] issue_rd_i;
    logic              flush_i;

    modport master (
        output dataW_i, rsW_i, RegWEn_i, rs1_i, rs2_i, issue_i, issue_rd_i, flush_i,
        input  data1_o, data2_o, busy1_o, busy2_o
    );

    modport slave (
        input  dataW_i, rsW_i, RegWEn_i, rs1_i, rs2_i, issue_i, issue_rd_i, flush_i,
        output data1_o, data2_o, busy1_o, busy2_o
    );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with a per-register pending-write (busy) scoreboard for RAW hazard detection.
// Latency: the write lands on the next rising edge, and reads are combinational (with optional same-cycle write bypass).
// Backpressure: none; every write, issue and flush is accepted in its cycle.
// Ports: clk_i/rst_i (async active-high reset); bus (reg_file_sb_if.slave) carries the write port,
//        the two read ports with their busy flags, and the issue/flush scoreboard controls.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    reg_file_sb_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic              we_eff;
    logic              issue_eff;

    // Writes to a hard-wired x0 are dropped entirely. They neither store nor clear busy.
    always_comb begin
        we_eff    = bus.RegWEn_i && !((ZERO_REG != 0) && (bus.rsW_i == '0));
        issue_eff = bus.issue_i && !((ZERO_REG != 0) && (bus.issue_rd_i == '0));
    end

    always_comb begin
        regs_d = regs_q;
        if (we_eff) begin
            regs_d[bus.rsW_i] = bus.dataW_i;
        end
    end

    // Flush drops any same-cycle issue. Otherwise the issue set is applied after the
    // writeback clear, so a new producer for the same register stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush_i) begin
            busy_d = '0;
        end else begin
            if (we_eff) begin
                busy_d[bus.rsW_i] = 1'b0;
            end
            if (issue_eff) begin
                busy_d[bus.issue_rd_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports. Outputs are forced to zero during reset so that the bypass path
    // cannot leak dataW_i while the array is held cleared.
    // A bypassed read also masks busy, because the pending value is being forwarded now.
    always_comb begin
        bus.data1_o = regs_q[bus.rs1_i];
        bus.busy1_o = busy_q[bus.rs1_i];
        if ((BYPASS != 0) && we_eff && (bus.rsW_i == bus.rs1_i)) begin
            bus.data1_o = bus.dataW_i;
            bus.busy1_o = 1'b0;
        end
        if ((ZERO_REG != 0) && (bus.rs1_i == '0)) begin
            bus.data1_o = '0;
            bus.busy1_o = 1'b0;
        end
        if (rst_i) begin
            bus.data1_o = '0;
            bus.busy1_o = 1'b0;
        end
    end

    always_comb begin
        bus.data2_o = regs_q[bus.rs2_i];
        bus.busy2_o = busy_q[bus.rs2_i];
        if ((BYPASS != 0) && we_eff && (bus.rsW_i == bus.rs2_i)) begin
            bus.data2_o = bus.dataW_i;
            bus.busy2_o = 1'b0;
        end
        if ((ZERO_REG != 0) && (bus.rs2_i == '0)) begin
            bus.data2_o = '0;
            bus.busy2_o = 1'b0;
        end
        if (rst_i) begin
            bus.data2_o = '0;
            bus.busy2_o = 1'b0;
        end
    end
endmodule
